// File: rtl/uart_hex_pkg.sv
// Shared types and constants for the UART hex reader: receiver states,
// ASCII control characters, error codes and a hex-digit decoder.
package uart_hex_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_LX = 8'h78;  // 'x'
   localparam logic [7:0] ASCII_UX = 8'h58;  // 'X'

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_FRAME = 2'b01;
   localparam logic [1:0] ERR_CHAR  = 2'b10;

   typedef struct packed {
      logic       ok;
      logic [3:0] nib;
   } hex_digit_t;

   // Maps '0'-'9', 'A'-'F', 'a'-'f' to a nibble. Letters share their low
   // nibble pattern (A=x1 .. F=x6), so adding 9 gives 10..15 for both cases.
   function automatic hex_digit_t decode_hex(input logic [7:0] c);
      hex_digit_t d;
      d.ok  = 1'b0;
      d.nib = 4'd0;
      if (c >= 8'h30 && c <= 8'h39) begin
         d.ok  = 1'b1;
         d.nib = c[3:0];
      end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
         d.ok  = 1'b1;
         d.nib = c[3:0] + 4'd9;
      end
      return d;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, baud counter sampling mid-bit,
// and a receive FSM that strobes each good byte or flags a framing error.
module uart_rx_byte
   import uart_hex_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] baud_div,
   input  logic        rx_pin,
   output logic [7:0]  data,
   output logic        byte_stb,
   output logic        frame_err,
   output logic        busy
);

   logic [1:0]  sync_q;
   logic        rx_s;
   rx_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        stb_d, ferr_d;

   assign rx_s = sync_q[1];

   // Bring the asynchronous line into the clock domain.
   // NOTE: the synchroniser resets to 1 (idle line level); resetting it to 0
   // would be seen as a start bit the moment reset releases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx_pin};
      end
   end

   // State, counter and shift-register updates.
   // NOTE: all state is updated with non-blocking assignments so every flop
   // sees the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         byte_stb  <= stb_d;
         frame_err <= ferr_d;
      end
   end

   // Next-state logic: count down to zero, sample, reload one bit period.
   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      stb_d   = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               // Bit period is captured here so a mid-byte change is ignored.
               state_d = RX_START;
               cnt_d   = baud_div >> 1;
               div_d   = baud_div;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d = RX_DATA;
                  cnt_d   = div_q - 16'd1;
                  bit_d   = 3'd0;
               end else begin
                  state_d = RX_IDLE;  // glitch, not a real start bit
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};  // LSB arrives first
               cnt_d   = div_q - 16'd1;
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  stb_d   = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign data = shift_q;
   assign busy = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP);

endmodule

// File: rtl/uart_hex_reader.sv
// UART hex reader: receives ASCII hex text, accumulates up to DIGITS_MAX
// digits and publishes the word on CR/LF with a one-cycle valid strobe.
module uart_hex_reader
   import uart_hex_pkg::*;
#(
   parameter int DIGITS_MAX = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] baud_div,
   input  logic        rx_pin,
   output logic [31:0] hex_val,
   output logic [3:0]  digits,
   output logic        valid,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        busy
);

   localparam logic [3:0] CNT_MAX = 4'(DIGITS_MAX);

   logic [7:0]  rx_data;
   logic        byte_stb;
   logic        frame_err;

   logic [31:0] acc_q, acc_d;
   logic [3:0]  count_q, count_d;
   logic [31:0] hex_d;
   logic [3:0]  digits_d;
   logic        valid_d, err_d;
   logic [1:0]  code_d;
   hex_digit_t  digit;

   uart_rx_byte u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_div  (baud_div),
      .rx_pin    (rx_pin),
      .data      (rx_data),
      .byte_stb  (byte_stb),
      .frame_err (frame_err),
      .busy      (busy)
   );

   // Parser: classify the received byte and decide accumulator/output updates.
   always_comb begin
      acc_d    = acc_q;
      count_d  = count_q;
      hex_d    = hex_val;
      digits_d = digits;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      code_d   = err_code;
      digit    = decode_hex(rx_data);
      if (frame_err) begin
         err_d   = 1'b1;
         code_d  = ERR_FRAME;
         acc_d   = '0;
         count_d = '0;
      end else if (byte_stb) begin
         if (digit.ok) begin
            acc_d   = {acc_q[27:0], digit.nib};
            count_d = (count_q >= CNT_MAX) ? CNT_MAX : count_q + 4'd1;
         end else if (rx_data == ASCII_LX || rx_data == ASCII_UX) begin
            acc_d   = '0;  // "0x" prefix: drop the leading zero
            count_d = '0;
         end else if (rx_data == ASCII_SP) begin
            acc_d   = acc_q;
         end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
            // Empty line (second half of CRLF) publishes nothing.
            if (count_q != '0) begin
               hex_d    = acc_q;
               digits_d = count_q;
               valid_d  = 1'b1;
               acc_d    = '0;
               count_d  = '0;
            end
         end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHAR;
            acc_d   = '0;
            count_d = '0;
         end
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         count_q  <= '0;
         hex_val  <= '0;
         digits   <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         acc_q    <= acc_d;
         count_q  <= count_d;
         hex_val  <= hex_d;
         digits   <= digits_d;
         valid    <= valid_d;
         err      <= err_d;
         err_code <= code_d;
      end
   end

endmodule

// File: tb/tb_uart_hex_reader.sv
// Directed testbench for uart_hex_reader: drives 8N1 frames at 16 clocks
// per bit and checks published words, error pulses and reset behaviour.
module tb_uart_hex_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] baud_div = 16'd16;
   logic        rx_pin = 1'b1;
   logic [31:0] hex_val;
   logic [3:0]  digits;
   logic        valid;
   logic        err;
   logic [1:0]  err_code;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Event monitor, sampled on the falling edge.
   int          n_valid = 0;
   int          n_err = 0;
   logic [31:0] last_hex = '0;
   logic [3:0]  last_dig = '0;
   logic [1:0]  last_code = '0;
   int          vrun = 0;
   int          vrun_max = 0;
   int          brun = 0;
   int          brun_last = 0;

   uart_hex_reader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_div (baud_div),
      .rx_pin   (rx_pin),
      .hex_val  (hex_val),
      .digits   (digits),
      .valid    (valid),
      .err      (err),
      .err_code (err_code),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         n_valid  = n_valid + 1;
         last_hex = hex_val;
         last_dig = digits;
         vrun     = vrun + 1;
         if (vrun > vrun_max) vrun_max = vrun;
      end else begin
         vrun = 0;
      end
      if (err) begin
         n_err     = n_err + 1;
         last_code = err_code;
      end
      if (busy) begin
         brun = brun + 1;
      end else if (brun != 0) begin
         brun_last = brun;
         brun      = 0;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      int bd;
      bd = int'(baud_div);
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (bd) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (bd) @(negedge clk);
      end
      rx_pin = stop;
      repeat (bd) @(negedge clk);
      rx_pin = 1'b1;
      repeat (bd) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i], 1'b1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({hex_val, digits, valid, err, err_code, busy} !== 41'd0) begin
         errors++;
         $display("FAIL reset_outputs: got hex=%h dig=%0d v=%b e=%b code=%b busy=%b, want all zero",
                  hex_val, digits, valid, err, err_code, busy);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if ({valid, err, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got v=%b e=%b busy=%b, want 000", valid, err, busy);
      end
   endtask

   task automatic test_full_word();
      int vb, eb;
      vb = n_valid; eb = n_err;
      send_str("33112244\r");
      repeat (20) @(negedge clk);
      checks++;
      if (n_valid - vb !== 1) begin errors++; $display("FAIL full_word_valid_count: got %0d want 1", n_valid - vb); end
      checks++;
      if (n_err - eb !== 0) begin errors++; $display("FAIL full_word_err_count: got %0d want 0", n_err - eb); end
      checks++;
      if (last_hex !== 32'h33112244) begin errors++; $display("FAIL full_word_hex: got %h want 33112244", last_hex); end
      checks++;
      if (last_dig !== 4'd8) begin errors++; $display("FAIL full_word_digits: got %0d want 8", last_dig); end
      checks++;
      if (hex_val !== 32'h33112244) begin errors++; $display("FAIL full_word_hold: got %h want 33112244", hex_val); end
   endtask

   task automatic test_prefix_crlf();
      int vb, eb;
      vb = n_valid; eb = n_err;
      send_str("0xab\r\n");
      repeat (20) @(negedge clk);
      checks++;
      if (n_valid - vb !== 1) begin errors++; $display("FAIL prefix_valid_count: got %0d want 1", n_valid - vb); end
      checks++;
      if (n_err - eb !== 0) begin errors++; $display("FAIL prefix_err_count: got %0d want 0", n_err - eb); end
      checks++;
      if (last_hex !== 32'h000000AB) begin errors++; $display("FAIL prefix_hex: got %h want 000000ab", last_hex); end
      checks++;
      if (last_dig !== 4'd2) begin errors++; $display("FAIL prefix_digits: got %0d want 2", last_dig); end
      checks++;
      if (digits !== 4'd2) begin errors++; $display("FAIL prefix_digits_hold: got %0d want 2", digits); end
   endtask

   task automatic test_overflow();
      int vb, eb;
      vb = n_valid; eb = n_err;
      send_str("123456789A\n");
      repeat (20) @(negedge clk);
      checks++;
      if (n_valid - vb !== 1) begin errors++; $display("FAIL overflow_valid_count: got %0d want 1", n_valid - vb); end
      checks++;
      if (n_err - eb !== 0) begin errors++; $display("FAIL overflow_err_count: got %0d want 0", n_err - eb); end
      checks++;
      if (last_hex !== 32'h3456789A) begin errors++; $display("FAIL overflow_hex: got %h want 3456789a", last_hex); end
      checks++;
      if (last_dig !== 4'd8) begin errors++; $display("FAIL overflow_digits: got %0d want 8", last_dig); end
   endtask

   task automatic test_bad_char();
      int vb, eb;
      vb = n_valid; eb = n_err;
      send_str("12G\r");
      repeat (20) @(negedge clk);
      checks++;
      if (n_err - eb !== 1) begin errors++; $display("FAIL bad_char_err_count: got %0d want 1", n_err - eb); end
      checks++;
      if (last_code !== 2'b10) begin errors++; $display("FAIL bad_char_code: got %b want 10", last_code); end
      checks++;
      if (n_valid - vb !== 0) begin errors++; $display("FAIL bad_char_valid_count: got %0d want 0", n_valid - vb); end
      checks++;
      if (hex_val !== 32'h3456789A) begin errors++; $display("FAIL bad_char_hold: got %h want 3456789a", hex_val); end
   endtask

   task automatic test_frame_err();
      int vb, eb;
      vb = n_valid; eb = n_err;
      send_str("12");
      send_byte(8'h41, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (n_err - eb !== 1) begin errors++; $display("FAIL frame_err_count: got %0d want 1", n_err - eb); end
      checks++;
      if (err_code !== 2'b01) begin errors++; $display("FAIL frame_err_code: got %b want 01", err_code); end
      checks++;
      if (n_valid - vb !== 0) begin errors++; $display("FAIL frame_valid_count: got %0d want 0", n_valid - vb); end
      vb = n_valid; eb = n_err;
      send_str("5\n");
      repeat (20) @(negedge clk);
      checks++;
      if (n_valid - vb !== 1) begin errors++; $display("FAIL frame_recover_valid: got %0d want 1", n_valid - vb); end
      checks++;
      if (last_hex !== 32'h00000005) begin errors++; $display("FAIL frame_recover_hex: got %h want 00000005", last_hex); end
      checks++;
      if (last_dig !== 4'd1) begin errors++; $display("FAIL frame_recover_digits: got %0d want 1", last_dig); end
   endtask

   task automatic test_glitch();
      int vb, eb;
      vb = n_valid; eb = n_err;
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (4) @(negedge clk);
      rx_pin = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (n_valid - vb !== 0 || n_err - eb !== 0) begin
         errors++;
         $display("FAIL glitch_events: got valid+%0d err+%0d want 0/0", n_valid - vb, n_err - eb);
      end
      checks++;
      if (brun_last < 1 || brun_last > 10) begin
         errors++;
         $display("FAIL glitch_busy_len: got %0d cycles want 1..10", brun_last);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_byte();
      int vb, eb;
      vb = n_valid; eb = n_err;
      @(negedge clk);
      rx_pin = 1'b0;                       // start bit
      repeat (16) @(negedge clk);
      rx_pin = 1'b1;                       // data bit 0
      repeat (16) @(negedge clk);
      rx_pin = 1'b0;                       // data bit 1
      repeat (8) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({hex_val, digits, valid, err, err_code, busy} !== 41'd0) begin
         errors++;
         $display("FAIL reset_mid_async: got hex=%h dig=%0d v=%b e=%b code=%b busy=%b, want all zero",
                  hex_val, digits, valid, err, err_code, busy);
      end
      rx_pin = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (n_valid - vb !== 0 || n_err - eb !== 0) begin
         errors++;
         $display("FAIL reset_mid_events: got valid+%0d err+%0d want 0/0", n_valid - vb, n_err - eb);
      end
      vb = n_valid;
      send_str("7\r");
      repeat (20) @(negedge clk);
      checks++;
      if (n_valid - vb !== 1) begin errors++; $display("FAIL after_reset_valid: got %0d want 1", n_valid - vb); end
      checks++;
      if (hex_val !== 32'h00000007) begin errors++; $display("FAIL after_reset_hex: got %h want 00000007", hex_val); end
      checks++;
      if (digits !== 4'd1) begin errors++; $display("FAIL after_reset_digits: got %0d want 1", digits); end
   endtask

   task automatic test_pulse_width();
      checks++;
      if (vrun_max !== 1) begin errors++; $display("FAIL valid_pulse_width: got %0d cycles want 1", vrun_max); end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_prefix_crlf();
      test_overflow();
      test_bad_char();
      test_frame_err();
      test_glitch();
      test_reset_mid_byte();
      test_pulse_width();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_hex_reader.md
Name: uart_hex_reader

Overview:
- Serial receive counterpart of uart_hex_logger: accepts ASCII hex text on a UART RX pin and assembles it into a 32-bit word.
- Presents the word with a one-cycle valid strobe so a bring-up top can drive sp_bram addresses/data from a host terminal.
- Two parts: a byte-level 8N1 receiver, then a hex/terminator parser.

Parameters:
- DIGITS_MAX, 8, max hex digits retained (32-bit word); extra digits shift older digits out the top.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_div  in  16  clock cycles per UART bit (234 = 115200 baud at 27 MHz); must be >= 4
- rx_pin  in  1  UART receive line, idle high, asynchronous to clk
- hex_val  out  32  last completed word, held until next completion
- digits  out  4  number of digits in the word (1..8, saturating), held with hex_val
- valid  out  1  one-cycle pulse: hex_val/digits updated
- err  out  1  one-cycle pulse on framing error or illegal character
- err_code  out  2  01 framing, 10 bad char; held until next err
- busy  out  1  high from start-bit detect to end of stop-bit sample

Behaviour:
- Reset (async, rst_n low): hex_val=0, digits=0, valid=0, err=0, err_code=0, busy=0, accumulator=0, count=0, RX FSM=IDLE, synchroniser flops=1.
- rx_pin passes through a 2-flop synchroniser; all logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: synchronised line low -> START, load counter = baud_div>>1, busy=1.
- START: counter at 0 -> sample. Low: DATA, counter = baud_div-1, bit=0. High: false start, return to IDLE with no error, busy=0.
- DATA: sample at counter 0, shift LSB first, reload baud_div-1. After bit 7 -> STOP.
- STOP: sample at counter 0, then busy=0.
  - High: byte strobe next cycle -> IDLE.
  - Low: framing error; err pulse, err_code=01, accumulator and count cleared -> WAIT_HIGH.
- WAIT_HIGH: stay until line high for 1 cycle -> IDLE.
- baud_div is sampled at start-bit detect. Changes mid-byte do not affect that byte.
- Parser acts in the cycle after the byte strobe:
  - '0'-'9','A'-'F','a'-'f': acc = {acc[27:0], nibble}; count = min(count+1, 8).
  - 'x'/'X': clear acc and count, so a "0x" prefix is accepted.
  - Space (0x20): ignored.
  - CR (0x0D) or LF (0x0A) with count>0: hex_val=acc, digits=count, valid pulse; acc and count cleared. With count=0, ignored, so CRLF yields a single word.
  - Any other byte: err pulse, err_code=10, acc and count cleared.
- Latency: valid/err asserts 2 cycles after the stop-bit sample cycle and lasts exactly 1 cycle.
- Fewer than 8 digits zero-extend (e.g. "AB" -> 0x000000AB). More than 8 keep the last 8.
- A framing error and a parser event cannot coincide: the framing error suppresses the byte strobe.
- Reset asserted mid-byte aborts immediately. No valid/err is produced for the partial byte.

Decomposition:
- Package uart_hex_pkg:
  - RX state encodings.
  - ASCII constants CR, LF, SP, 'x', 'X'.
  - err_code values ERR_FRAME=2'b01, ERR_CHAR=2'b10.
- Sub-module uart_rx_byte: synchroniser, baud counter, RX FSM.
  - Outputs: byte[7:0], byte_stb, frame_err, busy.
- Top uart_hex_reader: parser and output registers.

Test Plan:
- baud_div=16; send "33112244\r" -> one valid pulse, hex_val=0x33112244, digits=8, err never asserted.
- Send "0xab\r\n" -> exactly one valid, hex_val=0x000000AB, digits=2; LF produces nothing.
- Send "123456789A\n" -> hex_val=0x3456789A, digits=8.
- Send "12G\r" -> err pulse, err_code=10 on 'G'; CR then ignored (count=0); no valid.
- Send byte 0x41 with stop bit driven low, release line, then send "5\n":
  - err with err_code=01 on the bad frame; prior accumulator discarded.
  - Then valid with hex_val=0x00000005.
- 4-cycle low glitch on rx_pin -> no busy beyond START, no strobe, no err.
- rst_n low mid-DATA -> all outputs 0 asynchronously.
- After rst_n release, "7\r" -> hex_val=7.
